// File: rtl/ptp_sched_pulse_gen_if.sv
// Configuration bus of the PTP-scheduled pulse generator.
// cfg_wr is a one-cycle strobe with no back-pressure (always taken); cfg_err answers it exactly one cycle later.
interface ptp_sched_pulse_gen_if #(
  parameter int NUM_CH = 4,
  parameter int TIME_W = 64
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_sel;
  logic [TIME_W-1:0] cfg_wdata;
  logic              cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_sel, cfg_wdata, input cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_sel, cfg_wdata, output cfg_err);
endinterface

// File: rtl/ptp_sched_pulse_gen.sv
// Multi-channel periodic trigger generator whose deadlines are compared directly against PTP time,
// keeping launch pulses phase-locked to the PTP grid across servo corrections.
module ptp_sched_pulse_gen #(
  parameter int NUM_CH = 4,
  parameter int TIME_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TIME_W-1:0]       time_ptp_ns_i,
  input  logic [NUM_CH-1:0]       ch_enable_i,
  ptp_sched_pulse_gen_if.slave    cfg,
  output logic [NUM_CH-1:0]       tx_signal_o,
  output logic [NUM_CH-1:0]       ch_active_o,
  output logic [NUM_CH-1:0]       ch_done_o,
  output logic [NUM_CH-1:0]       miss_flag_o,
  output logic [NUM_CH*CNT_W-1:0] pulse_cnt_o,
  output logic [NUM_CH*3-1:0]     state_dbg_o
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_CATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [TIME_W-1:0] period_q [NUM_CH];
  logic [TIME_W-1:0] period_d [NUM_CH];
  logic [TIME_W-1:0] start_q [NUM_CH];
  logic [TIME_W-1:0] start_d [NUM_CH];
  logic [TIME_W-1:0] next_dl_q [NUM_CH];
  logic [TIME_W-1:0] next_dl_d [NUM_CH];
  logic [CNT_W-1:0]  limit_q [NUM_CH];
  logic [CNT_W-1:0]  limit_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [TIME_W-1:0] dl_inc [NUM_CH];
  logic [CNT_W-1:0]  cnt_inc [NUM_CH];
  logic [NUM_CH-1:0] tx_q, tx_d;
  logic [NUM_CH-1:0] miss_q, miss_d;
  logic              cfg_err_q, cfg_err_d;
  logic              wr_ok;

  always_comb begin
    cfg_err_d = 1'b0;
    wr_ok     = 1'b0;
    tx_d      = '0;
    miss_d    = miss_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      period_d[i]  = period_q[i];
      start_d[i]   = start_q[i];
      limit_d[i]   = limit_q[i];
      next_dl_d[i] = next_dl_q[i];
      cnt_d[i]     = cnt_q[i];
      dl_inc[i]    = next_dl_q[i] + period_q[i];
      cnt_inc[i]   = cnt_q[i] + CNT_W'(1);
    end

    // Config lands before the FSM so an arm in the same cycle sees the new value.
    if (cfg.cfg_wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg.cfg_ch == CH_W'(i) && cfg.cfg_sel != 2'd3 &&
            (state_q[i] == ST_IDLE || state_q[i] == ST_DONE)) begin
          wr_ok = 1'b1;
          case (cfg.cfg_sel)
            2'd0:    period_d[i] = cfg.cfg_wdata;
            2'd1:    start_d[i]  = cfg.cfg_wdata;
            default: limit_d[i]  = cfg.cfg_wdata[CNT_W-1:0];
          endcase
        end
      end
      cfg_err_d = !wr_ok;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      unique case (state_q[i])
        ST_IDLE: begin
          if (ch_enable_i[i] && period_d[i] != '0) begin
            state_d[i]   = ST_ARMED;
            next_dl_d[i] = start_d[i];
            cnt_d[i]     = '0;
            miss_d[i]    = 1'b0;
          end
        end
        ST_ARMED, ST_RUN: begin
          if (!ch_enable_i[i]) begin
            state_d[i] = ST_IDLE;
          end else if (time_ptp_ns_i >= next_dl_q[i]) begin
            tx_d[i]      = 1'b1;
            next_dl_d[i] = dl_inc[i];
            cnt_d[i]     = cnt_inc[i];
            if (limit_q[i] != '0 && cnt_inc[i] == limit_q[i]) begin
              state_d[i] = ST_DONE;
            end else if (time_ptp_ns_i >= dl_inc[i]) begin
              miss_d[i]  = 1'b1;
              state_d[i] = ST_CATCH;
            end else begin
              state_d[i] = ST_RUN;
            end
          end
        end
        ST_CATCH: begin
          // Skip stale deadlines one period per cycle, silently.
          if (!ch_enable_i[i]) begin
            state_d[i] = ST_IDLE;
          end else if (time_ptp_ns_i >= next_dl_q[i]) begin
            next_dl_d[i] = dl_inc[i];
          end else begin
            state_d[i] = ST_RUN;
          end
        end
        ST_DONE: begin
          if (!ch_enable_i[i]) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= ST_IDLE;
        period_q[i]  <= '0;
        start_q[i]   <= '0;
        limit_q[i]   <= '0;
        next_dl_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
      tx_q      <= '0;
      miss_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= state_d[i];
        period_q[i]  <= period_d[i];
        start_q[i]   <= start_d[i];
        limit_q[i]   <= limit_d[i];
        next_dl_q[i] <= next_dl_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
      tx_q      <= tx_d;
      miss_q    <= miss_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_active_o[i]              = (state_q[i] == ST_ARMED) || (state_q[i] == ST_RUN) ||
                                    (state_q[i] == ST_CATCH);
      ch_done_o[i]                = (state_q[i] == ST_DONE);
      pulse_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
      state_dbg_o[i*3 +: 3]       = state_q[i];
    end
  end

  assign tx_signal_o = tx_q;
  assign miss_flag_o = miss_q;
  assign cfg.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_ptp_sched_pulse_gen.sv
// Bench for ptp_sched_pulse_gen: directed plan steps plus a randomized phase, all checked
// against a deadline-level reference model of each channel.
module tb_ptp_sched_pulse_gen;
  localparam int NUM_CH = 4;
  localparam int TIME_W = 64;
  localparam int CNT_W  = 32;
  localparam int W      = NUM_CH * CNT_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [TIME_W-1:0]       t;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       tx_signal, ch_active, ch_done, miss_flag;
  logic [NUM_CH*CNT_W-1:0] pulse_cnt;
  logic [NUM_CH*3-1:0]     state_dbg;

  ptp_sched_pulse_gen_if #(.NUM_CH(NUM_CH), .TIME_W(TIME_W)) cfg_bus ();

  ptp_sched_pulse_gen #(.NUM_CH(NUM_CH), .TIME_W(TIME_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .time_ptp_ns_i (t),
    .ch_enable_i   (en),
    .cfg           (cfg_bus),
    .tx_signal_o   (tx_signal),
    .ch_active_o   (ch_active),
    .ch_done_o     (ch_done),
    .miss_flag_o   (miss_flag),
    .pulse_cnt_o   (pulse_cnt),
    .state_dbg_o   (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a deadline plus a few booleans.
  logic [NUM_CH-1:0] exp_q[$];
  logic [TIME_W-1:0] m_per [NUM_CH];
  logic [TIME_W-1:0] m_start [NUM_CH];
  logic [TIME_W-1:0] m_dl [NUM_CH];
  logic [CNT_W-1:0]  m_lim [NUM_CH];
  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  bit                m_live [NUM_CH];
  bit                m_fin [NUM_CH];
  bit                m_catch [NUM_CH];
  bit                m_miss [NUM_CH];
  logic              exp_err;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0d obs=%0h exp=%0h", tag, t, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_per[c] = '0; m_start[c] = '0; m_dl[c] = '0; m_lim[c] = '0; m_cnt[c] = '0;
      m_live[c] = 0; m_fin[c] = 0; m_catch[c] = 0; m_miss[c] = 0;
    end
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] tx_e;
    int ch;
    tx_e    = '0;
    exp_err = 1'b0;
    if (cfg_bus.cfg_wr) begin
      ch = int'(cfg_bus.cfg_ch);
      if (cfg_bus.cfg_sel == 2'd3 || m_live[ch]) exp_err = 1'b1;
      else if (cfg_bus.cfg_sel == 2'd0) m_per[ch] = cfg_bus.cfg_wdata;
      else if (cfg_bus.cfg_sel == 2'd1) m_start[ch] = cfg_bus.cfg_wdata;
      else m_lim[ch] = cfg_bus.cfg_wdata[CNT_W-1:0];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_fin[c]) begin
        if (!en[c]) m_fin[c] = 0;
      end else if (!m_live[c]) begin
        if (en[c] && m_per[c] != 0) begin
          m_live[c] = 1; m_dl[c] = m_start[c]; m_cnt[c] = 0; m_miss[c] = 0; m_catch[c] = 0;
        end
      end else if (!en[c]) begin
        m_live[c] = 0;
      end else if (m_catch[c]) begin
        if (m_dl[c] <= t) m_dl[c] = m_dl[c] + m_per[c];
        else m_catch[c] = 0;
      end else if (t >= m_dl[c]) begin
        tx_e[c]  = 1'b1;
        m_cnt[c] = m_cnt[c] + 1;
        m_dl[c]  = m_dl[c] + m_per[c];
        if (m_lim[c] != 0 && m_cnt[c] == m_lim[c]) begin
          m_live[c] = 0; m_fin[c] = 1;
        end else if (t >= m_dl[c]) begin
          m_miss[c] = 1; m_catch[c] = 1;
        end
      end
    end
    exp_q.push_back(tx_e);
  endtask

  // Scoreboard
  task automatic check_all();
    logic [NUM_CH-1:0] e_tx, e_act, e_done, e_miss;
    logic [W-1:0]      e_cnt;
    e_tx = exp_q.pop_front();
    for (int c = 0; c < NUM_CH; c++) begin
      e_act[c]  = m_live[c];
      e_done[c] = m_fin[c];
      e_miss[c] = m_miss[c];
      e_cnt[c*CNT_W +: CNT_W] = m_cnt[c];
    end
    chk("tx_signal", W'(tx_signal), W'(e_tx));
    chk("ch_active", W'(ch_active), W'(e_act));
    chk("ch_done",   W'(ch_done),   W'(e_done));
    chk("miss_flag", W'(miss_flag), W'(e_miss));
    chk("pulse_cnt", pulse_cnt,     e_cnt);
    chk("cfg_err",   W'(cfg_bus.cfg_err), W'(exp_err));
  endtask

  // Driver tasks
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic tick();
    step();
    t = t + 8;
  endtask

  task automatic cfg_write(input int ch, input int sel, input logic [TIME_W-1:0] data);
    cfg_bus.cfg_wr    = 1'b1;
    cfg_bus.cfg_ch    = ch[1:0];
    cfg_bus.cfg_sel   = sel[1:0];
    cfg_bus.cfg_wdata = data;
    step();
    cfg_bus.cfg_wr    = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tx"},   W'(tx_signal), '0);
    chk({tag, "_act"},  W'(ch_active), '0);
    chk({tag, "_done"}, W'(ch_done),   '0);
    chk({tag, "_miss"}, W'(miss_flag), '0);
    chk({tag, "_cnt"},  pulse_cnt,     '0);
    chk({tag, "_err"},  W'(cfg_bus.cfg_err), '0);
  endtask

  logic [TIME_W-1:0] start3;
  int                r;
  int                sel;

  initial begin
    rst = 1'b1; en = '0; t = '0;
    cfg_bus.cfg_wr = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_sel = '0; cfg_bus.cfg_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Channel 0: 1000/5000 unlimited; channel 1: 400/1000 limited to 3 pulses
    cfg_write(0, 0, 64'd1000);
    cfg_write(0, 1, 64'd5000);
    cfg_write(1, 0, 64'd400);
    cfg_write(1, 1, 64'd1000);
    cfg_write(1, 2, 64'd3);
    en = 4'b0011;
    while (t < 64'd2600) tick();
    chk("ch1_done_after_3", W'(ch_done[1]), W'(1'b1));
    chk("ch1_inactive", W'(ch_active[1]), W'(1'b0));
    chk("ch1_cnt_3", W'(pulse_cnt[1*CNT_W +: CNT_W]), W'(32'd3));
    while (t < 64'd6008) tick();
    chk("ch0_cnt_2", W'(pulse_cnt[0 +: CNT_W]), W'(32'd2));
    chk("ch0_no_miss", W'(miss_flag[0]), W'(1'b0));

    // Write to a running channel is rejected
    cfg_write(0, 0, 64'd500);
    chk("run_write_err", W'(cfg_bus.cfg_err), W'(1'b1));
    step();
    chk("err_one_cycle", W'(cfg_bus.cfg_err), W'(1'b0));

    // Time jump: one late pulse, then resume on the 1000 ns grid
    t = 64'd10500;
    step();
    chk("jump_pulse", W'(tx_signal[0]), W'(1'b1));
    chk("jump_miss", W'(miss_flag[0]), W'(1'b1));
    chk("jump_cnt", W'(pulse_cnt[0 +: CNT_W]), W'(32'd3));
    t = t + 8;
    while (t < 64'd11000) tick();
    tick();
    chk("grid_11000", W'(tx_signal[0]), W'(1'b1));
    chk("grid_cnt", W'(pulse_cnt[0 +: CNT_W]), W'(32'd4));
    while (t < 64'd12008) tick();
    chk("grid_cnt_12000", W'(pulse_cnt[0 +: CNT_W]), W'(32'd5));

    // Same write accepted once the channel is idle
    en[0] = 1'b0;
    tick();
    chk("ch0_idle", W'(ch_active[0]), W'(1'b0));
    cfg_write(0, 0, 64'd500);
    chk("idle_write_ok", W'(cfg_bus.cfg_err), W'(1'b0));

    // Enable with period 0 never arms
    en[2] = 1'b1;
    repeat (5) tick();
    chk("zero_period_idle", W'(ch_active[2]), W'(1'b0));

    // Drop enable on the deadline-hit cycle
    cfg_write(3, 0, 64'd100);
    start3 = t + 80;
    cfg_write(3, 1, start3);
    en[3] = 1'b1;
    while (t < start3) tick();
    en[3] = 1'b0;
    step();
    chk("drop_no_pulse", W'(tx_signal[3]), W'(1'b0));
    chk("drop_idle", W'(ch_active[3]), W'(1'b0));

    // Randomized phase
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) t = t + 64'($urandom_range(100, 3000));
      else if (r < 7 && t > 64'd600) t = t - 64'($urandom_range(1, 500));
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
      if ($urandom_range(0, 9) == 0) begin
        sel = $urandom_range(0, 3);
        cfg_bus.cfg_wr  = 1'b1;
        cfg_bus.cfg_ch  = 2'($urandom_range(0, NUM_CH - 1));
        cfg_bus.cfg_sel = sel[1:0];
        if (sel == 0) cfg_bus.cfg_wdata = 64'($urandom_range(0, 600));
        else if (sel == 1) cfg_bus.cfg_wdata = t + 64'($urandom_range(0, 2000));
        else cfg_bus.cfg_wdata = 64'($urandom_range(0, 5));
      end
      step();
      cfg_bus.cfg_wr = 1'b0;
      t = t + 8;
    end

    // Asynchronous reset in the middle of a run
    en = '0;
    tick();
    cfg_write(0, 0, 64'd300);
    cfg_write(0, 1, t);
    cfg_write(0, 2, 64'd0);
    en[0] = 1'b1;
    repeat (3) tick();
    chk("pre_reset_cnt", W'(pulse_cnt[0 +: CNT_W]), W'(32'd1));
    #3;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
    chk("post_rst_period0", W'(ch_active[0]), W'(1'b0));
    cfg_write(0, 0, 64'd300);
    chk("write_and_arm", W'(ch_active[0]), W'(1'b1));
    tick();
    chk("start0_pulse", W'(tx_signal[0]), W'(1'b1));
    chk("start0_cnt", W'(pulse_cnt[0 +: CNT_W]), W'(32'd1));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ptp_sched_pulse_gen.md
Name: ptp_sched_pulse_gen

Overview:
Multi-channel, PTP-time-scheduled periodic trigger generator for the traffic generator TX path. Each channel has its own start time, period and pulse count. Deadlines are compared directly against PTP time, not a free-running cycle counter, so pulses stay phase-locked to the PTP grid across servo corrections. Each tx_signal bit drives one TX frame-launch engine.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
TIME_W, 64, width of PTP time, period and start values in ns
CNT_W, 32, width of per-channel pulse-count limit and pulse counter

Ports:
clk  in  1  TX clock
rst  in  1  reset, asynchronous, active-high
time_ptp_ns  in  TIME_W  current PTP time in ns, monotonic except on servo step
ch_enable  in  NUM_CH  per-channel run enable, level-sensitive
cfg_wr  in  1  config write strobe, one cycle
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_sel  in  2  0=period_ns, 1=start_ns, 2=count_limit (0 = unlimited), 3=reserved
cfg_wdata  in  TIME_W  write data; count_limit uses low CNT_W bits
cfg_err  out  1  one-cycle pulse: write rejected
tx_signal  out  NUM_CH  one-cycle launch pulse per channel
ch_active  out  NUM_CH  channel in ARMED or RUN
ch_done  out  NUM_CH  channel in DONE
miss_flag  out  NUM_CH  sticky: channel skipped at least one deadline; clears when the channel leaves IDLE
pulse_cnt  out  NUM_CH*CNT_W  pulses issued since arm; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset: all outputs 0, every channel IDLE. Config registers reset to period=0, start=0, count_limit=0.
- Config writes:
  - Accepted only when the target channel is IDLE or DONE.
  - Rejected, with cfg_err pulsed the next cycle, if the channel is ARMED or RUN, cfg_sel=3, or cfg_ch>=NUM_CH.
- Per-channel FSM (all transitions registered):
  - IDLE: on ch_enable=1 and period!=0 -> ARMED. Load next_dl=start, clear pulse_cnt and miss_flag. If ch_enable=1 and period==0, stay IDLE with no error.
  - ARMED/RUN: when time_ptp_ns >= next_dl, tx_signal pulses exactly one cycle on the next clock, next_dl += period, pulse_cnt += 1, state -> RUN.
  - Count limit: if count_limit!=0 and the incremented pulse_cnt == count_limit -> DONE.
  - Late deadline: if time_ptp_ns >= next_dl + period at a deadline hit (late by one or more periods), issue a single pulse, set miss_flag, and enter catch-up. In catch-up, next_dl advances by period once per cycle with no pulses and no pulse_cnt increment until next_dl > time_ptp_ns.
  - DONE: tx_signal held 0. On ch_enable=0 -> IDLE.
  - ch_enable=0 in ARMED or RUN (including catch-up) -> IDLE on the next clock. A pulse already registered for that same cycle is suppressed.
- Latency: the tx_signal pulse appears one clk after the first sampled time_ptp_ns >= next_dl.
- Arithmetic: next_dl + period wraps modulo 2^TIME_W with no special handling. Comparisons are unsigned.
- Backward time step: no pulses until time reaches next_dl. Deadlines are never rewound.
- Channels are fully independent. Simultaneous deadlines on several channels pulse in the same cycle.
- Simultaneous cfg_wr and ch_enable rise on the same channel: the write lands first, and arming uses the new value.

Test Plan:
- Channel 0: period=1000, start=5000, limit=0. Time steps by 8 ns from 0, enable at t=0 -> pulses at the cycles after t=5000, 6000, 7000, ...; pulse_cnt increments by 1 each; miss_flag=0.
- Channel 1: limit=3, period=400, start=1000 -> exactly 3 pulses (after 1000, 1400, 1800). ch_done=1 and ch_active=0 after the third; no pulse at 2200.
- Time jump during channel 0 run: from t=6008 step to t=10500 -> exactly one pulse, miss_flag=1, no further pulse until t>=11000, pulses resume on the 1000-ns grid.
- cfg_wr period=500 to channel 0 while RUN -> cfg_err pulses one cycle, period unchanged. Same write after disable -> accepted, cfg_err=0.
- Enable with period=0 -> ch_active stays 0, no pulses. Drop ch_enable the cycle a deadline is hit -> no pulse, IDLE next cycle.
- Assert rst mid-run (asynchronous, between edges) -> tx_signal, ch_active, pulse_cnt, miss_flag go to 0 immediately. After release and re-enable, the first pulse occurs at start (config reset to 0 -> immediate pulse only if period was rewritten nonzero).
